// File: rtl/axis_forwarder_pkg.sv
// Shared definitions for the forwarder and the filter-tree blocks:
// FSM encoding, default sizes and the packet-length width derivation.
package axis_forwarder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE,
        HOLD
    } fwd_state_e;

    localparam int SNOOP_FWD_ADDR_WIDTH_DEF = 9;
    localparam int DATA_WIDTH_DEF           = 64;
    localparam int FIFO_DEPTH_DEF           = 4;

    // A length of 2^addr_width words needs one bit more than the address.
    function automatic int plen_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/axis_forwarder_if.sv
// Forwarder-side bundle: packet handoff from the tree root, packet-memory
// read port and the AXI4-Stream master output.
interface axis_forwarder_if
    import axis_forwarder_pkg::*;
#(
    parameter int SNOOP_FWD_ADDR_WIDTH = SNOOP_FWD_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH           = DATA_WIDTH_DEF,
    parameter int PLEN_WIDTH           = plen_width(SNOOP_FWD_ADDR_WIDTH)
) ();

    logic                            ready_for_forwarder;
    logic [PLEN_WIDTH-1:0]           len_to_forwarder;
    logic [SNOOP_FWD_ADDR_WIDTH-1:0] forwarder_rd_addr;
    logic                            forwarder_rd_en;
    logic [DATA_WIDTH-1:0]           forwarder_rd_data;
    logic                            forwarder_done;
    logic [DATA_WIDTH-1:0]           m_axis_tdata;
    logic                            m_axis_tvalid;
    logic                            m_axis_tlast;
    logic                            m_axis_tready;

    modport master (
        input  ready_for_forwarder, len_to_forwarder, forwarder_rd_data, m_axis_tready,
        output forwarder_rd_addr, forwarder_rd_en, forwarder_done,
               m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        output ready_for_forwarder, len_to_forwarder, forwarder_rd_data, m_axis_tready,
        input  forwarder_rd_addr, forwarder_rd_en, forwarder_done,
               m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

endinterface

// File: rtl/axis_forwarder_fwd_out_fifo.sv
// Small synchronous output FIFO; the head entry is visible combinationally
// so the stream side can present it the cycle after it is written.
module fwd_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; emptiness is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/axis_forwarder.sv
// Reads an accepted packet out of packet memory and streams it as an
// AXI4-Stream master, then pulses forwarder_done to release the buffer.
module axis_forwarder
    import axis_forwarder_pkg::*;
#(
    parameter int SNOOP_FWD_ADDR_WIDTH = SNOOP_FWD_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH           = DATA_WIDTH_DEF,
    parameter int PLEN_WIDTH           = plen_width(SNOOP_FWD_ADDR_WIDTH),
    parameter int FIFO_DEPTH           = FIFO_DEPTH_DEF
) (
    input  logic               axi_aclk,
    input  logic               axi_aresetn,
    axis_forwarder_if.master   fwd
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fwd_state_e            state_q, state_d;
    logic [PLEN_WIDTH-1:0] len_q, len_d;
    logic [PLEN_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [PLEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                  inflight_q;

    logic                  rd_en;
    logic                  credit_ok;
    logic [CNT_W:0]        occupancy;
    logic                  push_last;
    logic                  pop;
    logic [DATA_WIDTH:0]   fifo_head;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;

    // Credit uses only registered state, so tready never reaches rd_en.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign credit_ok = (occupancy < (CNT_W+1)'(FIFO_DEPTH)) && !fifo_full;
    assign rd_en     = (state_q == STREAM) && (rd_ptr_q < len_q) && credit_ok;
    assign push_last = (beat_cnt_q == len_q - PLEN_WIDTH'(1));
    assign pop       = fwd.m_axis_tvalid && fwd.m_axis_tready;

    fwd_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_out_fifo (
        .clk_i   (axi_aclk),
        .rst_ni  (axi_aresetn),
        .push_i  (inflight_q),
        .data_i  ({push_last, fwd.forwarder_rd_data}),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rd_ptr_d   = rd_ptr_q;
        beat_cnt_d = beat_cnt_q;
        if (rd_en)      rd_ptr_d   = rd_ptr_q + PLEN_WIDTH'(1);
        if (inflight_q) beat_cnt_d = beat_cnt_q + PLEN_WIDTH'(1);
        case (state_q)
            IDLE: begin
                if (fwd.ready_for_forwarder) begin
                    len_d      = fwd.len_to_forwarder;
                    rd_ptr_d   = '0;
                    beat_cnt_d = '0;
                    state_d    = (fwd.len_to_forwarder == '0) ? DONE : STREAM;
                end
            end
            STREAM:  if (pop && fifo_head[DATA_WIDTH]) state_d = DONE;
            DONE:    state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state_q    <= IDLE;
            len_q      <= '0;
            rd_ptr_q   <= '0;
            beat_cnt_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rd_ptr_q   <= rd_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            inflight_q <= rd_en;
        end
    end

    // Head contents are masked while empty so a flushed FIFO shows zeros.
    assign fwd.forwarder_rd_en   = rd_en;
    assign fwd.forwarder_rd_addr = rd_ptr_q[SNOOP_FWD_ADDR_WIDTH-1:0];
    assign fwd.forwarder_done    = (state_q == DONE);
    assign fwd.m_axis_tvalid     = !fifo_empty;
    assign fwd.m_axis_tdata      = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
    assign fwd.m_axis_tlast      = !fifo_empty && fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_axis_forwarder.sv
// Self-checking bench for axis_forwarder: a packet-memory model, a negedge
// monitor logging reads/beats/done pulses, and one task per scenario.
module tb_axis_forwarder;

    localparam int AW    = 9;
    localparam int DW    = 64;
    localparam int PW    = 10;
    localparam int DEPTH = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axis_forwarder_if #(.SNOOP_FWD_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PLEN_WIDTH(PW)) bus ();

    axis_forwarder #(
        .SNOOP_FWD_ADDR_WIDTH (AW),
        .DATA_WIDTH           (DW),
        .PLEN_WIDTH           (PW),
        .FIFO_DEPTH           (DEPTH)
    ) dut (
        .axi_aclk    (clk),
        .axi_aresetn (rstn),
        .fwd         (bus.master)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (bus.forwarder_rd_en) bus.forwarder_rd_data <= mem[bus.forwarder_rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    int            rd_q[$];
    int            rd_cyc_q[$];
    logic [DW-1:0] beat_data_q[$];
    bit            beat_last_q[$];
    int            beat_cyc_q[$];
    int            done_q[$];
    int            tv_cycles = 0;

    int            reads_n = 0;
    int            beats_n = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    // Monitor: logs activity and checks the credit limit and stall stability.
    always @(negedge clk) begin
        if (bus.forwarder_rd_en) begin
            checks++;
            if (reads_n - beats_n >= DEPTH) begin
                errors++;
                $display("[TB] FAIL credit: rd_en with %0d words outstanding, required < %0d", reads_n - beats_n, DEPTH);
            end
            rd_q.push_back(int'(bus.forwarder_rd_addr));
            rd_cyc_q.push_back(cyc);
            reads_n++;
        end
        if (prev_stall) begin
            checks++;
            if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== prev_data || bus.m_axis_tlast !== prev_last) begin
                errors++;
                $display("[TB] FAIL stall_hold: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                         bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, prev_data, prev_last);
            end
        end
        if (bus.m_axis_tvalid === 1'b1) tv_cycles++;
        if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1) begin
            beat_data_q.push_back(bus.m_axis_tdata);
            beat_last_q.push_back(bus.m_axis_tlast);
            beat_cyc_q.push_back(cyc);
            beats_n++;
        end
        if (bus.forwarder_done === 1'b1) done_q.push_back(cyc);
        prev_stall = (bus.m_axis_tvalid === 1'b1) && (bus.m_axis_tready !== 1'b1);
        prev_data  = bus.m_axis_tdata;
        prev_last  = bus.m_axis_tlast;
        if (!rstn) begin
            reads_n    = 0;
            beats_n    = 0;
            prev_stall = 1'b0;
        end
    end

    task automatic clear_log();
        rd_q.delete(); rd_cyc_q.delete();
        beat_data_q.delete(); beat_last_q.delete(); beat_cyc_q.delete();
        done_q.delete();
        tv_cycles = 0;
    endtask

    task automatic start_packet(input int len, output int t0);
        @(posedge clk); #1;
        bus.ready_for_forwarder = 1'b1;
        bus.len_to_forwarder    = PW'(len);
        t0 = cyc;
        @(posedge clk); #1;
        bus.ready_for_forwarder = 1'b0;
    endtask

    task automatic run_until_done(input int target, input int budget, input int pct, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done_q.size() >= target) begin
                ok = 1'b1;
                break;
            end
            bus.m_axis_tready = ($urandom_range(0, 99) < pct);
        end
        bus.m_axis_tready = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (bus.forwarder_rd_en !== 1'b0)   begin errors++; $display("[TB] FAIL reset_rd_en: got %b, expected 0", bus.forwarder_rd_en); end
        if (bus.forwarder_rd_addr !== '0)   begin errors++; $display("[TB] FAIL reset_rd_addr: got %h, expected 0", bus.forwarder_rd_addr); end
        if (bus.forwarder_done !== 1'b0)    begin errors++; $display("[TB] FAIL reset_done: got %b, expected 0", bus.forwarder_done); end
        if (bus.m_axis_tvalid !== 1'b0)     begin errors++; $display("[TB] FAIL reset_tvalid: got %b, expected 0", bus.m_axis_tvalid); end
        if (bus.m_axis_tlast !== 1'b0)      begin errors++; $display("[TB] FAIL reset_tlast: got %b, expected 0", bus.m_axis_tlast); end
        if (bus.m_axis_tdata !== '0)        begin errors++; $display("[TB] FAIL reset_tdata: got %h, expected 0", bus.m_axis_tdata); end
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        int t0; bit ok;
        for (int i = 0; i < 4; i++) mem[i] = 64'hA0 + DW'(i);
        bus.m_axis_tready = 1'b1;
        clear_log();
        start_packet(4, t0);
        run_until_done(1, 50, 100, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_timeout: got no done, expected done"); end
        checks++;
        if (rd_cyc_q.size() == 0 || rd_cyc_q[0] != t0 + 1) begin
            errors++; $display("[TB] FAIL basic_first_rd: got cycle %0d, expected %0d", rd_cyc_q.size() ? rd_cyc_q[0] : -1, t0 + 1);
        end
        checks++; if (beat_data_q.size() != 4) begin errors++; $display("[TB] FAIL basic_beats: got %0d, expected 4", beat_data_q.size()); end
        for (int i = 0; i < 4 && i < beat_data_q.size(); i++) begin
            checks++;
            if (beat_data_q[i] !== 64'hA0 + DW'(i) || beat_last_q[i] !== (i == 3) || beat_cyc_q[i] != t0 + 3 + i) begin
                errors++;
                $display("[TB] FAIL basic_beat[%0d]: got d=%h l=%b c=%0d, expected d=%h l=%b c=%0d", i,
                         beat_data_q[i], beat_last_q[i], beat_cyc_q[i], 64'hA0 + DW'(i), (i == 3), t0 + 3 + i);
            end
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != t0 + 7) begin
            errors++; $display("[TB] FAIL basic_done: got %0d pulses first at %0d, expected 1 at %0d",
                               done_q.size(), done_q.size() ? done_q[0] : -1, t0 + 7);
        end
    endtask

    task automatic test_backpressure();
        int t0; bit ok;
        clear_log();
        start_packet(9, t0);
        run_until_done(1, 400, 50, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_timeout: got no done, expected done"); end
        checks++; if (rd_q.size() != 9) begin errors++; $display("[TB] FAIL bp_reads: got %0d, expected 9", rd_q.size()); end
        for (int i = 0; i < 9 && i < rd_q.size(); i++) begin
            checks++; if (rd_q[i] != i) begin errors++; $display("[TB] FAIL bp_addr[%0d]: got %0d, expected %0d", i, rd_q[i], i); end
        end
        checks++; if (beat_data_q.size() != 9) begin errors++; $display("[TB] FAIL bp_beats: got %0d, expected 9", beat_data_q.size()); end
        for (int i = 0; i < 9 && i < beat_data_q.size(); i++) begin
            checks++;
            if (beat_data_q[i] !== mem[i] || beat_last_q[i] !== (i == 8)) begin
                errors++; $display("[TB] FAIL bp_beat[%0d]: got d=%h l=%b, expected d=%h l=%b", i, beat_data_q[i], beat_last_q[i], mem[i], (i == 8));
            end
        end
        checks++; if (done_q.size() != 1) begin errors++; $display("[TB] FAIL bp_done: got %0d pulses, expected 1", done_q.size()); end
    endtask

    task automatic test_zero_length();
        int t0; bit ok;
        clear_log();
        start_packet(0, t0);
        run_until_done(1, 20, 100, ok);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (!ok || done_q.size() != 1 || done_q[0] != t0 + 1) begin
            errors++; $display("[TB] FAIL zero_done: got %0d pulses first at %0d, expected 1 at %0d",
                               done_q.size(), done_q.size() ? done_q[0] : -1, t0 + 1);
        end
        checks++; if (rd_q.size() != 0) begin errors++; $display("[TB] FAIL zero_reads: got %0d, expected 0", rd_q.size()); end
        checks++; if (tv_cycles != 0) begin errors++; $display("[TB] FAIL zero_tvalid: got %0d valid cycles, expected 0", tv_cycles); end
    endtask

    task automatic test_max_length();
        int t0; bit ok; int n;
        n = 1 << AW;
        clear_log();
        start_packet(n, t0);
        run_until_done(1, 3000, 80, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL max_timeout: got no done, expected done"); end
        checks++; if (rd_q.size() != n) begin errors++; $display("[TB] FAIL max_reads: got %0d, expected %0d", rd_q.size(), n); end
        for (int i = 0; i < n && i < rd_q.size(); i++) begin
            checks++; if (rd_q[i] != i) begin errors++; $display("[TB] FAIL max_addr[%0d]: got %0d, expected %0d", i, rd_q[i], i); end
        end
        checks++; if (beat_data_q.size() != n) begin errors++; $display("[TB] FAIL max_beats: got %0d, expected %0d", beat_data_q.size(), n); end
        for (int i = 0; i < n && i < beat_data_q.size(); i++) begin
            checks++;
            if (beat_data_q[i] !== mem[i] || beat_last_q[i] !== (i == n - 1)) begin
                errors++; $display("[TB] FAIL max_beat[%0d]: got d=%h l=%b, expected d=%h l=%b", i, beat_data_q[i], beat_last_q[i], mem[i], (i == n - 1));
            end
        end
        checks++;
        if (done_q.size() != 1 || beat_cyc_q.size() != n || done_q[0] != beat_cyc_q[n-1] + 1) begin
            errors++; $display("[TB] FAIL max_done: got %0d pulses first at %0d, expected 1 right after last beat",
                               done_q.size(), done_q.size() ? done_q[0] : -1);
        end
    endtask

    task automatic test_mid_reset();
        int t0; bit ok; int lasts;
        bus.m_axis_tready = 1'b1;
        clear_log();
        start_packet(8, t0);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (beat_data_q.size() >= 2) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("[TB] FAIL mid_wait: got %0d beats, expected 2", beat_data_q.size()); end
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.forwarder_rd_en !== 1'b0 || bus.forwarder_rd_addr !== '0 || bus.forwarder_done !== 1'b0 ||
            bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tlast !== 1'b0 || bus.m_axis_tdata !== '0) begin
            errors++; $display("[TB] FAIL mid_outputs: got en=%b a=%h dn=%b v=%b l=%b d=%h, expected all 0",
                               bus.forwarder_rd_en, bus.forwarder_rd_addr, bus.forwarder_done,
                               bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        lasts = 0;
        foreach (beat_last_q[i]) if (beat_last_q[i]) lasts++;
        checks++; if (done_q.size() != 0) begin errors++; $display("[TB] FAIL mid_done: got %0d pulses, expected 0", done_q.size()); end
        checks++; if (lasts != 0) begin errors++; $display("[TB] FAIL mid_tlast: got %0d, expected 0", lasts); end
        mem[0] = {$urandom, $urandom};
        mem[1] = {$urandom, $urandom};
        clear_log();
        start_packet(2, t0);
        run_until_done(1, 40, 100, ok);
        checks++;
        if (!ok || beat_data_q.size() != 2 || done_q.size() != 1) begin
            errors++; $display("[TB] FAIL mid_fresh: got %0d beats %0d dones, expected 2 beats 1 done", beat_data_q.size(), done_q.size());
        end
        for (int i = 0; i < 2 && i < beat_data_q.size(); i++) begin
            checks++;
            if (beat_data_q[i] !== mem[i] || beat_last_q[i] !== (i == 1) || beat_cyc_q[i] != t0 + 3 + i) begin
                errors++; $display("[TB] FAIL mid_fresh_beat[%0d]: got d=%h l=%b c=%0d, expected d=%h l=%b c=%0d", i,
                                   beat_data_q[i], beat_last_q[i], beat_cyc_q[i], mem[i], (i == 1), t0 + 3 + i);
            end
        end
    endtask

    task automatic test_ready_held();
        int t1; bit ok;
        bus.m_axis_tready = 1'b1;
        clear_log();
        @(posedge clk); #1;
        bus.ready_for_forwarder = 1'b1;
        bus.len_to_forwarder    = PW'(2);
        run_until_done(1, 40, 100, ok);
        @(posedge clk); #1;
        bus.ready_for_forwarder = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (!ok || rd_q.size() != 2 || done_q.size() != 1 || beat_data_q.size() != 2) begin
            errors++; $display("[TB] FAIL held_first: got %0d reads %0d beats %0d dones, expected 2 2 1",
                               rd_q.size(), beat_data_q.size(), done_q.size());
        end
        start_packet(1, t1);
        run_until_done(2, 40, 100, ok);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (!ok || rd_q.size() != 3 || done_q.size() != 2 || beat_data_q.size() != 3) begin
            errors++; $display("[TB] FAIL held_second: got %0d reads %0d beats %0d dones, expected 3 3 2",
                               rd_q.size(), beat_data_q.size(), done_q.size());
        end else begin
            checks++;
            if (rd_q[2] != 0 || beat_data_q[2] !== mem[0] || beat_last_q[2] !== 1'b1 || beat_cyc_q[2] != t1 + 3) begin
                errors++; $display("[TB] FAIL held_beat: got a=%0d d=%h l=%b c=%0d, expected a=0 d=%h l=1 c=%0d",
                                   rd_q[2], beat_data_q[2], beat_last_q[2], beat_cyc_q[2], mem[0], t1 + 3);
            end
        end
    endtask

    initial begin
        bus.ready_for_forwarder = 1'b0;
        bus.len_to_forwarder    = '0;
        bus.m_axis_tready       = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom};
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_length();
        test_max_length();
        test_mid_reset();
        test_ready_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
